// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types: the fetch entry carried from fetch into decode
// and reused by later pipeline registers.
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] inst;
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] pc4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Fetch-to-decode queue: DEPTH-entry FIFO of {inst, pc, pc4} with flush on redirect.
// Head is read combinationally from storage, so an entry pushed into an empty queue is visible right after its edge.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     f_valid,
  output logic                     f_ready,
  input  logic [XLEN-1:0]          INST_F,
  input  logic [XLEN-1:0]          PC_F,
  input  logic [XLEN-1:0]          PC4_F,
  output logic                     d_valid,
  input  logic                     d_ready,
  output logic [XLEN-1:0]          INST_D,
  output logic [XLEN-1:0]          PC_D,
  output logic [XLEN-1:0]          PC4_D,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Storage is data only: never reset, masked at the outputs while empty.
  fetch_entry_t mem [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          push;
  logic          pop;
  fetch_entry_t  head;

  // f_ready depends only on registered occupancy, never on d_ready.
  assign f_ready = (cnt != CW'(DEPTH));
  assign d_valid = (cnt != '0);
  assign push    = f_valid && f_ready;
  assign pop     = d_valid && d_ready;
  assign count   = cnt;
  assign head    = mem[rd_ptr];

  // Control state: reset beats flush, flush discards any same-cycle push/pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !flush && push) begin
      mem[wr_ptr].inst <= INST_F;
      mem[wr_ptr].pc   <= PC_F;
      mem[wr_ptr].pc4  <= PC4_F;
    end
  end

  always_comb begin
    INST_D = '0;
    PC_D   = '0;
    PC4_D  = '0;
    if (d_valid) begin
      INST_D = head.inst;
      PC_D   = head.pc;
      PC4_D  = head.pc4;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus a randomized run against a queue model.
module tb_fetch_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_n, flush, f_valid, f_ready, d_valid, d_ready;
  logic [XLEN-1:0]   INST_F, PC_F, PC4_F, INST_D, PC_D, PC4_D;
  logic [2:0]        count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
  } ent_t;

  ent_t q[$];

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .f_valid(f_valid), .f_ready(f_ready),
    .INST_F(INST_F), .PC_F(PC_F), .PC4_F(PC4_F),
    .d_valid(d_valid), .d_ready(d_ready),
    .INST_D(INST_D), .PC_D(PC_D), .PC4_D(PC4_D),
    .count(count)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fetch(input logic v, input logic [XLEN-1:0] pc);
    f_valid = v;
    PC_F    = pc;
    PC4_F   = pc + 32'd4;
    INST_F  = 32'h0000_0013 ^ (pc << 8);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; d_ready = 1'b0; set_fetch(1'b0, '0);
    cyc(); cyc();
    rst_n = 1'b1;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_checks++; if (f_ready !== 1'b1) begin n_fail++; $display("FAIL reset_f_ready got %b want 1", f_ready); end
    n_checks++; if (d_valid !== 1'b0) begin n_fail++; $display("FAIL reset_d_valid got %b want 0", d_valid); end
    n_checks++; if ({INST_D, PC_D, PC4_D} !== '0) begin n_fail++; $display("FAIL reset_outputs got %h/%h/%h want 0", INST_D, PC_D, PC4_D); end
  endtask

  task automatic test_single();
    f_valid = 1'b1; INST_F = 32'h0000_0013; PC_F = 32'h0; PC4_F = 32'h4; d_ready = 1'b1;
    cyc();
    f_valid = 1'b0;
    n_checks++; if (d_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", d_valid); end
    n_checks++; if (INST_D !== 32'h13) begin n_fail++; $display("FAIL single_inst got %h want 00000013", INST_D); end
    n_checks++; if (PC4_D !== 32'h4) begin n_fail++; $display("FAIL single_pc4 got %h want 00000004", PC4_D); end
    n_checks++; if (PC_D !== 32'h0) begin n_fail++; $display("FAIL single_pc got %h want 00000000", PC_D); end
    cyc();
    n_checks++; if (d_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain_valid got %b want 0", d_valid); end
    n_checks++; if ({INST_D, PC_D, PC4_D} !== '0) begin n_fail++; $display("FAIL single_bubble got %h/%h/%h want 0", INST_D, PC_D, PC4_D); end
  endtask

  task automatic test_fill();
    d_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_fetch(1'b1, 32'(4 * i));
      cyc();
    end
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count got %0d want 4", count); end
    n_checks++; if (f_ready !== 1'b0) begin n_fail++; $display("FAIL fill_f_ready got %b want 0", f_ready); end
    set_fetch(1'b1, 32'h10);
    cyc();
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_fifth_count got %0d want 4", count); end
    n_checks++; if (PC_D !== 32'h0) begin n_fail++; $display("FAIL fill_stall_head got %h want 00000000", PC_D); end
    set_fetch(1'b0, '0);
    d_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (PC_D !== 32'(4 * i) || d_valid !== 1'b1) begin
        n_fail++; $display("FAIL fill_pop_order got pc=%h v=%b want pc=%h v=1", PC_D, d_valid, 32'(4 * i));
      end
      cyc();
    end
    n_checks++; if (d_valid !== 1'b0) begin n_fail++; $display("FAIL fill_empty_valid got %b want 0", d_valid); end
    d_ready = 1'b0;
  endtask

  task automatic test_simultaneous();
    d_ready = 1'b0;
    set_fetch(1'b1, 32'h100); cyc();
    set_fetch(1'b1, 32'h104); cyc();
    set_fetch(1'b1, 32'h108); d_ready = 1'b1; cyc();
    set_fetch(1'b0, '0); d_ready = 1'b0;
    n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL simul_count got %0d want 2", count); end
    n_checks++; if (PC_D !== 32'h104) begin n_fail++; $display("FAIL simul_head got %h want 00000104", PC_D); end
    d_ready = 1'b1; cyc();
    n_checks++; if (PC_D !== 32'h108) begin n_fail++; $display("FAIL simul_next got %h want 00000108", PC_D); end
    cyc();
    d_ready = 1'b0;
  endtask

  task automatic test_flush();
    d_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_fetch(1'b1, 32'h200 + 32'(4 * i)); cyc();
    end
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL flush_pre_count got %0d want 3", count); end
    flush = 1'b1; set_fetch(1'b1, 32'h2F0); d_ready = 1'b1;
    cyc();
    flush = 1'b0; set_fetch(1'b0, '0); d_ready = 1'b0;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL flush_count got %0d want 0", count); end
    n_checks++; if (d_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b want 0", d_valid); end
    cyc();
    n_checks++; if (count !== 3'd0 || PC_D !== 32'h0) begin n_fail++; $display("FAIL flush_absent got count=%0d pc=%h want 0/0", count, PC_D); end
  endtask

  task automatic test_wrap();
    d_ready = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      set_fetch(k < 10, 32'h300 + 32'(4 * k));
      n_checks++;
      if (k == 0) begin
        if (d_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_start got v=%b want 0", d_valid); end
      end else if (d_valid !== 1'b1 || PC_D !== 32'h300 + 32'(4 * (k - 1))) begin
        n_fail++; $display("FAIL wrap_order got v=%b pc=%h want v=1 pc=%h", d_valid, PC_D, 32'h300 + 32'(4 * (k - 1)));
      end
      cyc();
    end
    set_fetch(1'b0, '0);
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL wrap_end_count got %0d want 0", count); end
    d_ready = 1'b0;
  endtask

  task automatic test_reset_full();
    d_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_fetch(1'b1, 32'h400 + 32'(4 * i)); cyc();
    end
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL rstfull_pre got %0d want 4", count); end
    rst_n = 1'b0; flush = 1'b1; d_ready = 1'b1; set_fetch(1'b1, 32'h4F0);
    cyc();
    rst_n = 1'b1; flush = 1'b0; d_ready = 1'b0; set_fetch(1'b0, '0);
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL rstfull_count got %0d want 0", count); end
    n_checks++; if (f_ready !== 1'b1 || d_valid !== 1'b0) begin n_fail++; $display("FAIL rstfull_hs got f_ready=%b d_valid=%b want 1/0", f_ready, d_valid); end
    n_checks++; if ({INST_D, PC_D, PC4_D} !== '0) begin n_fail++; $display("FAIL rstfull_outputs got %h/%h/%h want 0", INST_D, PC_D, PC4_D); end
  endtask

  task automatic test_random();
    ent_t e;
    ent_t exp_head;
    int   sz;
    q.delete();
    for (int c = 0; c < 600; c++) begin
      rst_n   = ($urandom_range(0, 99) != 0);
      flush   = ($urandom_range(0, 39) == 0);
      d_ready = ($urandom_range(0, 99) < 60);
      f_valid = ($urandom_range(0, 99) < 65);
      INST_F  = $urandom; PC_F = $urandom; PC4_F = $urandom;
      sz = q.size();
      exp_head = '{default: '0};
      if (sz != 0) exp_head = q[0];
      n_checks++; if (count !== 3'(sz)) begin n_fail++; $display("FAIL rand_count c=%0d got %0d want %0d", c, count, sz); end
      n_checks++; if (f_ready !== (sz < DEPTH)) begin n_fail++; $display("FAIL rand_f_ready c=%0d got %b want %b", c, f_ready, sz < DEPTH); end
      n_checks++; if (d_valid !== (sz != 0)) begin n_fail++; $display("FAIL rand_d_valid c=%0d got %b want %b", c, d_valid, sz != 0); end
      n_checks++;
      if (INST_D !== exp_head.inst || PC_D !== exp_head.pc || PC4_D !== exp_head.pc4) begin
        n_fail++; $display("FAIL rand_head c=%0d got %h/%h/%h want %h/%h/%h", c, INST_D, PC_D, PC4_D, exp_head.inst, exp_head.pc, exp_head.pc4);
      end
      if (!rst_n || flush) begin
        q.delete();
      end else begin
        if (d_ready && sz != 0) void'(q.pop_front());
        if (f_valid && sz < DEPTH) begin
          e.inst = INST_F; e.pc = PC_F; e.pc4 = PC4_F;
          q.push_back(e);
        end
      end
      cyc();
    end
    rst_n = 1'b1; flush = 1'b0; f_valid = 1'b0; d_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; d_ready = 1'b0; set_fetch(1'b0, '0);
    #1;
    test_reset();
    test_single();
    test_fill();
    test_simultaneous();
    test_flush();
    test_wrap();
    test_reset_full();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning instruction/PC width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, meaning entry count; power of two, >= 2.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port flush  input  1  discards all queued entries (branch/jump redirect).
REQ-006 SHALL have port f_valid  input  1  fetch presents a valid entry.
REQ-007 SHALL have port f_ready  output  1  queue can accept an entry this cycle.
REQ-008 SHALL have port INST_F  input  XLEN  fetched instruction.
REQ-009 SHALL have port PC_F  input  XLEN  PC of fetched instruction.
REQ-010 SHALL have port PC4_F  input  XLEN  PC+4 of fetched instruction.
REQ-011 SHALL have port d_valid  output  1  head entry valid for decode.
REQ-012 SHALL have port d_ready  input  1  decode consumes head this cycle (deasserted = stall).
REQ-013 SHALL have port INST_D  output  XLEN  head instruction.
REQ-014 SHALL have port PC_D  output  XLEN  head PC.
REQ-015 SHALL have port PC4_D  output  XLEN  head PC+4.
REQ-016 SHALL have port count  output  $clog2(DEPTH)+1  occupied entries, 0..DEPTH.

Function
REQ-017 SHALL push when f_valid && f_ready; SHALL pop when d_valid && d_ready.
REQ-018 SHALL drive f_ready = (count < DEPTH), with no combinational dependence on d_ready.
REQ-019 SHALL drive d_valid = (count != 0).
REQ-020 SHALL drive INST_D/PC_D/PC4_D from the head entry when d_valid=1, and all zero when d_valid=0 (bubble).
REQ-021 SHALL add one cycle of latency: an entry pushed on edge N appears on the D outputs after edge N when the queue was empty.
REQ-022 SHALL preserve FIFO order; the head entry and its outputs SHALL hold stable while d_valid && !d_ready.
REQ-023 SHALL, on simultaneous push and pop, leave count unchanged and advance both pointers.
REQ-024 SHALL wrap read and write pointers modulo DEPTH without loss or duplication.
REQ-025 SHALL, when flush=1, set count to 0 and both pointers to 0 on the next edge; a same-cycle push or pop SHALL be discarded.
REQ-026 SHALL ignore f_valid while full, leaving state unchanged; upstream must hold its entry.
REQ-027 SHALL treat d_ready while empty as no-op; count SHALL never underflow or exceed DEPTH.

Reset
REQ-028 SHALL, when rst_n=0 at a rising edge, set count=0, pointers=0, d_valid=0, f_ready=1, and all D outputs to 0.
REQ-029 SHALL let reset take priority over flush, push and pop, including mid-operation with a full queue.
REQ-030 SHALL not require storage array contents to be cleared; D outputs SHALL still read zero while empty.

Structure
REQ-031 SHALL define a packed struct fetch_entry_t {inst, pc, pc4} (XLEN each) in shared package riscv_pkg, used for storage and reusable by later pipe registers.
REQ-032 SHALL hold the XLEN default constant in riscv_pkg; DEPTH stays a module parameter.
REQ-033 SHALL use no sub-module: the entry array, pointers and count live in one module.

Verification
REQ-034 SHALL cover: after reset, push INST 0x00000013/PC 0x0, d_ready=1 -> next cycle d_valid=1, INST_D=0x13, PC4_D=0x4; following cycle d_valid=0 and outputs 0.
REQ-035 SHALL cover: d_ready=0, push 4 entries with PC 0x0,0x4,0x8,0xC -> count=4, f_ready=0; a 5th push is ignored; d_ready=1 then pops PCs in order 0x0..0xC.
REQ-036 SHALL cover: count=2, push and pop in the same cycle -> count stays 2, and head advances to the second entry.
REQ-037 SHALL cover: count=3, flush=1 with f_valid=1 -> next cycle count=0, d_valid=0, and the pushed entry is absent.
REQ-038 SHALL cover: 10 continuous pushes and pops with PC stepping by 4 (pointer wrap at DEPTH=4) -> outputs in exact PC order, no gaps or duplicates.
REQ-039 SHALL cover: full queue, then rst_n=0 for one cycle -> count=0, f_ready=1, d_valid=0, and all D outputs 0.
